// File: rtl/double_adder_master.sv
// Initiator for the double_adder stb/ack protocol. It sources operand pairs from
// two Galois LFSRs and keeps a count, a snapshot and a checksum of the results.
module double_adder_master #(
  parameter logic [63:0] SEED_A  = 64'h3FF0000000000000,
  parameter logic [63:0] SEED_B  = 64'h4000000000000000,
  parameter logic [31:0] NUM_TXN = 32'd16,
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [63:0] input_a,
  output logic        input_a_stb,
  input  logic        input_a_ack,
  output logic [63:0] input_b,
  output logic        input_b_stb,
  input  logic        input_b_ack,
  input  logic [63:0] output_z,
  input  logic        output_z_stb,
  output logic        output_z_ack,
  output logic [63:0] last_a,
  output logic [63:0] last_b,
  output logic [63:0] last_z,
  output logic        result_valid,
  output logic [31:0] txn_count,
  output logic [63:0] checksum,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  // A zero seed would lock the LFSR at zero forever
  localparam logic [63:0] SEED_A_EFF = (SEED_A == 64'd0) ? 64'd1 : SEED_A;
  localparam logic [63:0] SEED_B_EFF = (SEED_B == 64'd0) ? 64'd1 : SEED_B;
  localparam logic [63:0] LFSR_TAPS  = 64'hD800000000000000;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  typedef enum logic [2:0] {IDLE, SEND, WAIT_Z, DONE, ERR} state_t;

  state_t      state, next_state;
  logic [63:0] lfsr_a, lfsr_b;
  logic [15:0] wait_cnt;
  logic        a_xfer, b_xfer, z_xfer, any_xfer;
  logic        wait_expired, last_txn, send_done;

  assign a_xfer       = input_a_stb & input_a_ack;
  assign b_xfer       = input_b_stb & input_b_ack;
  assign z_xfer       = output_z_ack & output_z_stb;
  assign any_xfer     = a_xfer | b_xfer | z_xfer;
  assign wait_expired = (({1'b0, wait_cnt} + 17'd1) >= {1'b0, TIMEOUT}) & ~any_xfer;
  assign last_txn     = (NUM_TXN != 32'd0) && ((txn_count + 32'd1) == NUM_TXN);
  assign send_done    = (~input_a_stb | a_xfer) & (~input_b_stb | b_xfer);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start) next_state = SEND;
      SEND: begin
        if (send_done)         next_state = WAIT_Z;
        else if (wait_expired) next_state = ERR;
      end
      WAIT_Z: begin
        if (z_xfer)            next_state = last_txn ? DONE : SEND;
        else if (wait_expired) next_state = ERR;
      end
      ERR:     next_state = ERR;
      default: next_state = IDLE;
    endcase
  end

  // Wait counter restarts whenever the handshake makes progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 16'd0;
    end else if ((next_state != state) || any_xfer) begin
      wait_cnt <= 16'd0;
    end else if ((state == SEND) || (state == WAIT_Z)) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_a       <= SEED_A_EFF;
      lfsr_b       <= SEED_B_EFF;
      input_a      <= 64'd0;
      input_b      <= 64'd0;
      input_a_stb  <= 1'b0;
      input_b_stb  <= 1'b0;
      output_z_ack <= 1'b0;
      last_a       <= 64'd0;
      last_b       <= 64'd0;
      last_z       <= 64'd0;
      result_valid <= 1'b0;
      txn_count    <= 32'd0;
      checksum     <= 64'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            lfsr_a      <= SEED_A_EFF;
            lfsr_b      <= SEED_B_EFF;
            input_a     <= SEED_A_EFF;
            input_b     <= SEED_B_EFF;
            input_a_stb <= 1'b1;
            input_b_stb <= 1'b1;
            txn_count   <= 32'd0;
            checksum    <= 64'd0;
            done        <= 1'b0;
            busy        <= 1'b1;
          end
        end
        SEND: begin
          if (a_xfer) input_a_stb <= 1'b0;
          if (b_xfer) input_b_stb <= 1'b0;
          if (next_state == WAIT_Z) output_z_ack <= 1'b1;
          if (next_state == ERR) begin
            input_a_stb <= 1'b0;
            input_b_stb <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        WAIT_Z: begin
          if (z_xfer) begin
            output_z_ack <= 1'b0;
            last_a       <= input_a;
            last_b       <= input_b;
            last_z       <= output_z;
            result_valid <= 1'b1;
            txn_count    <= txn_count + 32'd1;
            checksum     <= {checksum[62:0], checksum[63]} ^ output_z;
            lfsr_a       <= lfsr_step(lfsr_a);
            lfsr_b       <= lfsr_step(lfsr_b);
            // Next operands go out with the re-raised strobes
            if (last_txn) begin
              done <= 1'b1;
              busy <= 1'b0;
            end else begin
              input_a     <= lfsr_step(lfsr_a);
              input_b     <= lfsr_step(lfsr_b);
              input_a_stb <= 1'b1;
              input_b_stb <= 1'b1;
            end
          end else if (next_state == ERR) begin
            output_z_ack <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b1;
          end
        end
        default: begin
          input_a_stb  <= 1'b0;
          input_b_stb  <= 1'b0;
          output_z_ack <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_double_adder_master.sv
// Directed bench for double_adder_master, driven by a configurable responder
// that can add either as IEEE doubles or as plain 64-bit integers.
module tb_double_adder_master;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [63:0] input_a, input_b, output_z;
  logic        input_a_stb, input_a_ack, input_b_stb, input_b_ack;
  logic        output_z_stb, output_z_ack;
  logic [63:0] last_a, last_b, last_z, checksum;
  logic        result_valid, busy, done, timeout_err;
  logic [31:0] txn_count;

  int vectors = 0;
  int miscompares = 0;

  int a_delay = 0, b_delay = 0, z_delay = 0;
  bit z_never = 0, use_real = 0;
  int a_cnt = 0, b_cnt = 0, z_cnt = 0;
  logic [63:0] cap_a = 64'd0, cap_b = 64'd0;

  double_adder_master #(
    .NUM_TXN(32'd4),
    .TIMEOUT(16'd100)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
    .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack),
    .last_a(last_a), .last_b(last_b), .last_z(last_z),
    .result_valid(result_valid), .txn_count(txn_count), .checksum(checksum),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Responder: acks and results change on the falling edge only
  initial begin
    input_a_ack = 1'b0; input_b_ack = 1'b0;
    output_z_stb = 1'b0; output_z = 64'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        input_a_ack = 1'b0; input_b_ack = 1'b0; output_z_stb = 1'b0;
        a_cnt = 0; b_cnt = 0; z_cnt = 0;
      end else begin
        if (input_a_stb) begin
          if (a_cnt >= a_delay) begin input_a_ack = 1'b1; cap_a = input_a; end
          else begin input_a_ack = 1'b0; a_cnt++; end
        end else begin input_a_ack = 1'b0; a_cnt = 0; end
        if (input_b_stb) begin
          if (b_cnt >= b_delay) begin input_b_ack = 1'b1; cap_b = input_b; end
          else begin input_b_ack = 1'b0; b_cnt++; end
        end else begin input_b_ack = 1'b0; b_cnt = 0; end
        if (output_z_ack && !z_never) begin
          if (z_cnt >= z_delay) begin
            output_z_stb = 1'b1;
            output_z = use_real ? $realtobits($bitstoreal(cap_a) + $bitstoreal(cap_b))
                                : cap_a + cap_b;
          end else begin output_z_stb = 1'b0; z_cnt++; end
        end else begin output_z_stb = 1'b0; z_cnt = 0; end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_to_done(input int budget, output int pulses, output logic [63:0] z1,
                             output logic [63:0] a2, output logic [63:0] b2, output bit ok);
    pulses = 0; ok = 0; z1 = 64'd0; a2 = 64'd0; b2 = 64'd0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (result_valid) begin
        pulses++;
        if (pulses == 1) z1 = last_z;
        if (pulses == 2) begin a2 = last_a; b2 = last_b; end
      end
      if (done || timeout_err) begin ok = done; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({input_a_stb, input_b_stb, output_z_ack, result_valid, busy, done, timeout_err} !== 7'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b expected 0",
               {input_a_stb, input_b_stb, output_z_ack, result_valid, busy, done, timeout_err});
    end
    vectors++;
    if (txn_count !== 32'd0) begin
      miscompares++; $display("[TB] FAIL reset_count: got %h expected 0", txn_count);
    end
    vectors++;
    if ((checksum | last_a | last_b | last_z | input_a | input_b) !== 64'd0) begin
      miscompares++; $display("[TB] FAIL reset_data: got nonzero data, checksum %h last_z %h", checksum, last_z);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_full_run();
    int pulses; logic [63:0] z1, a2, b2; bit ok;
    use_real = 1;
    pulse_start();
    run_to_done(300, pulses, z1, a2, b2, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL full_run_done: got 0 expected 1"); end
    vectors++;
    if (z1 !== 64'h4008000000000000) begin
      miscompares++; $display("[TB] FAIL first_z: got %h expected 4008000000000000", z1);
    end
    vectors++;
    if (pulses !== 4) begin miscompares++; $display("[TB] FAIL pulse_count: got %0d expected 4", pulses); end
    vectors++;
    if (txn_count !== 32'd4) begin miscompares++; $display("[TB] FAIL txn_count: got %0d expected 4", txn_count); end
    vectors++;
    if ({busy, done} !== 2'b01) begin miscompares++; $display("[TB] FAIL end_flags: got busy,done=%b expected 01", {busy, done}); end
    vectors++;
    if ((last_a !== 64'h07FE000000000000) || (last_b !== 64'h0800000000000000)) begin
      miscompares++; $display("[TB] FAIL last_ops: got %h %h expected 07fe000000000000 0800000000000000", last_a, last_b);
    end
  endtask

  task automatic test_checksum();
    int pulses; logic [63:0] z1, a2, b2; bit ok;
    use_real = 0;
    for (int run = 0; run < 2; run++) begin
      pulse_start();
      run_to_done(300, pulses, z1, a2, b2, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("[TB] FAIL checksum_run%0d_done: got 0 expected 1", run); end
      vectors++;
      if (checksum !== 64'h3066000000000003) begin
        miscompares++; $display("[TB] FAIL checksum_run%0d: got %h expected 3066000000000003", run, checksum);
      end
      vectors++;
      if ((a2 !== 64'h1FF8000000000000) || (b2 !== 64'h2000000000000000)) begin
        miscompares++; $display("[TB] FAIL txn2_ops_run%0d: got %h %h expected 1ff8000000000000 2000000000000000", run, a2, b2);
      end
      vectors++;
      if (last_z !== 64'h0FFE000000000000) begin
        miscompares++; $display("[TB] FAIL last_z_run%0d: got %h expected 0ffe000000000000", run, last_z);
      end
    end
  endtask

  task automatic test_b_stall();
    int pulses; logic [63:0] z1, a2, b2; bit ok;
    logic [63:0] b_held;
    b_delay = 10;
    pulse_start();
    b_held = input_b;
    vectors++;
    if (b_held !== 64'h4000000000000000) begin
      miscompares++; $display("[TB] FAIL stall_b_initial: got %h expected 4000000000000000", b_held);
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      vectors++;
      if ({input_a_stb, input_b_stb} !== 2'b01 || input_b !== 64'h4000000000000000) begin
        miscompares++;
        $display("[TB] FAIL stall_cycle%0d: got a_stb,b_stb=%b b=%h expected 01 4000000000000000",
                 k, {input_a_stb, input_b_stb}, input_b);
      end
    end
    b_delay = 0;
    run_to_done(300, pulses, z1, a2, b2, ok);
    vectors++;
    if (!ok || txn_count !== 32'd4) begin
      miscompares++; $display("[TB] FAIL stall_run_done: got done=%b count=%0d expected 1 4", ok, txn_count);
    end
  endtask

  task automatic test_z_delay();
    int pulses; logic [63:0] z1, a2, b2; bit ok, seen;
    int hi;
    z_delay = 20; seen = 0; hi = 0;
    pulse_start();
    for (int i = 0; i < 30; i++) begin
      if (output_z_ack) begin seen = 1; break; end
      @(negedge clk);
    end
    while (output_z_ack && hi < 200) begin hi++; @(negedge clk); end
    z_delay = 0;
    vectors++;
    if (!seen || hi !== 21) begin
      miscompares++; $display("[TB] FAIL z_ack_window: got %0d cycles expected 21", hi);
    end
    vectors++;
    if ({output_z_ack, result_valid, timeout_err} !== 3'b010) begin
      miscompares++; $display("[TB] FAIL z_after_xfer: got ack,rv,err=%b expected 010",
                              {output_z_ack, result_valid, timeout_err});
    end
    run_to_done(300, pulses, z1, a2, b2, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("[TB] FAIL z_delay_run_done: got 0 expected 1"); end
  endtask

  task automatic test_reset_mid();
    int pulses; logic [63:0] z1, a2, b2; bit ok, seen;
    int rv;
    z_delay = 5; rv = 0; seen = 0;
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (result_valid) rv++;
      if (rv >= 2 && output_z_ack) begin seen = 1; break; end
    end
    vectors++;
    if (!seen) begin miscompares++; $display("[TB] FAIL mid_reach_wait_z: got 0 expected 1"); end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({input_a_stb, input_b_stb, output_z_ack, busy, result_valid} !== 5'd0 ||
        txn_count !== 32'd0 || (checksum | last_z | input_a) !== 64'd0) begin
      miscompares++; $display("[TB] FAIL mid_reset_clear: got ack=%b busy=%b count=%0d checksum=%h expected all 0",
                              output_z_ack, busy, txn_count, checksum);
    end
    @(negedge clk); rst = 1'b1; z_delay = 0;
    pulse_start();
    vectors++;
    if (input_a !== 64'h3FF0000000000000 || input_b !== 64'h4000000000000000 || input_a_stb !== 1'b1) begin
      miscompares++; $display("[TB] FAIL restart_ops: got %h %h stb=%b expected 3ff0000000000000 4000000000000000 1",
                              input_a, input_b, input_a_stb);
    end
    run_to_done(300, pulses, z1, a2, b2, ok);
    vectors++;
    if (!ok || pulses !== 4) begin
      miscompares++; $display("[TB] FAIL restart_run: got done=%b pulses=%0d expected 1 4", ok, pulses);
    end
  endtask

  task automatic test_timeout();
    bit seen; int hi;
    z_never = 1; seen = 0; hi = 0;
    pulse_start();
    for (int i = 0; i < 30; i++) begin
      if (output_z_ack) begin seen = 1; break; end
      @(negedge clk);
    end
    while (output_z_ack && hi < 300) begin hi++; @(negedge clk); end
    vectors++;
    if (!seen || hi !== 100) begin
      miscompares++; $display("[TB] FAIL timeout_window: got %0d cycles expected 100", hi);
    end
    vectors++;
    if ({timeout_err, busy, input_a_stb, input_b_stb, output_z_ack} !== 5'b10000) begin
      miscompares++; $display("[TB] FAIL timeout_flags: got err,busy,stbs,ack=%b expected 10000",
                              {timeout_err, busy, input_a_stb, input_b_stb, output_z_ack});
    end
    pulse_start();
    repeat (3) @(negedge clk);
    vectors++;
    if ({timeout_err, busy, input_a_stb, input_b_stb} !== 4'b1000) begin
      miscompares++; $display("[TB] FAIL err_ignores_start: got %b expected 1000",
                              {timeout_err, busy, input_a_stb, input_b_stb});
    end
    z_never = 0;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (timeout_err !== 1'b0) begin
      miscompares++; $display("[TB] FAIL err_cleared_by_reset: got %b expected 0", timeout_err);
    end
    rst = 1'b1;
  endtask

  initial begin
    $display("[TB] double_adder_master directed tests");
    test_reset();
    test_full_run();
    test_checksum();
    test_b_stall();
    test_z_delay();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
